// File: rtl/seq_calc_pkg.sv
// Shared definitions for the sequential calculator core: op encoding and FSM states.
package seq_calc_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_calc_muldiv.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide, one bit per cycle.
// Both ops share one {hi, lo} register pair, so the result is {hi, lo} in either case.
module seq_calc_muldiv
  import seq_calc_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_start,
  input  logic           i_is_div,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_done,
  output logic [2*W-1:0] o_result
);

  logic [CW-1:0] r_cnt;
  logic          r_is_div;
  logic [W-1:0]  r_hi;
  logic [W-1:0]  r_lo;
  logic [W-1:0]  r_opnd;

  logic [W:0]     w_mul_sum;
  logic [2*W-1:0] w_mul_next;
  logic [W:0]     w_div_sh;
  logic           w_div_ge;
  logic [W-1:0]   w_div_rem;
  logic [2*W-1:0] w_div_next;

  // The partial remainder stays below the divisor, so a W-bit subtract is exact.
  always_comb begin
    w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});
    w_mul_next = {w_mul_sum, r_lo[W-1:1]};
    w_div_sh   = {r_hi, r_lo[W-1]};
    w_div_ge   = (w_div_sh >= {1'b0, r_opnd});
    w_div_rem  = w_div_ge ? (w_div_sh[W-1:0] - r_opnd) : w_div_sh[W-1:0];
    w_div_next = {w_div_rem, r_lo[W-2:0], w_div_ge};
  end

  assign o_result = r_is_div ? w_div_next : w_mul_next;
  assign o_done   = (r_cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
    end else if (i_start) begin
      r_cnt    <= CW'(W);
      r_is_div <= i_is_div;
      r_hi     <= '0;
      r_lo     <= i_is_div ? i_a : i_b;
      r_opnd   <= i_is_div ? i_b : i_a;
    end else if (r_cnt != '0) begin
      r_cnt        <= r_cnt - CW'(1);
      {r_hi, r_lo} <= o_result;
    end
  end

endmodule

// File: rtl/seq_calc_core.sv
// Sequential calculator core: command/result handshakes, single-cycle ops, accumulator, flags.
// state | meaning
// IDLE  | waiting for a command, in_ready high
// RUN   | iterative MUL/DIV in progress (W cycles)
// DONE  | result valid, waiting for out_ready
module seq_calc_core
  import seq_calc_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           use_acc,
  input  logic           acc_clr,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] result,
  output logic           flag_zero,
  output logic           flag_carry,
  output logic           flag_dz,
  output logic           busy
);

  state_t         r_state;
  logic [W-1:0]   r_acc;
  logic [2*W-1:0] r_result;
  logic           r_fz;
  logic           r_fc;
  logic           r_fdz;
  logic           r_out_valid;

  logic [W-1:0]   w_a;
  logic [W:0]     w_add;
  logic [W:0]     w_sub;
  logic [2*W-1:0] w_res;
  logic           w_carry;
  logic           w_dz;
  logic           w_long;
  logic           w_start;
  logic           w_md_done;
  logic [2*W-1:0] w_md_result;

  always_comb begin
    w_a     = use_acc ? r_acc : a;
    w_add   = {1'b0, w_a} + {1'b0, b};
    w_sub   = {1'b0, w_a} - {1'b0, b};
    w_res   = '0;
    w_carry = 1'b0;
    w_dz    = 1'b0;
    case (op)
      OP_ADD: begin
        w_res   = {{(W-1){1'b0}}, w_add};
        w_carry = w_add[W];
      end
      OP_SUB: begin
        w_res   = {{W{1'b0}}, w_sub[W-1:0]};
        w_carry = w_sub[W];
      end
      OP_MUL: w_res = '0;
      OP_DIV: begin
        // Only reaches the output when b == 0; otherwise the iterative path runs.
        w_res = {w_a, {W{1'b1}}};
        w_dz  = 1'b1;
      end
      OP_OR:  w_res = {{W{1'b0}}, w_a | b};
      OP_XOR: w_res = {{W{1'b0}}, w_a ^ b};
      default: w_res = {{W{1'b0}}, w_a & b};
    endcase
    w_long  = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
    w_start = (r_state == IDLE) && in_valid && w_long;
  end

  seq_calc_muldiv #(.W(W), .CW(CW)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_start),
    .i_is_div (op == OP_DIV),
    .i_a      (w_a),
    .i_b      (b),
    .o_done   (w_md_done),
    .o_result (w_md_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_result    <= '0;
      r_fz        <= 1'b0;
      r_fc        <= 1'b0;
      r_fdz       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (w_long) begin
              r_state <= RUN;
            end else begin
              r_state     <= DONE;
              r_result    <= w_res;
              r_fz        <= (w_res == '0);
              r_fc        <= w_carry;
              r_fdz       <= w_dz;
              r_out_valid <= 1'b1;
              r_acc       <= w_res[W-1:0];
            end
          end
        end
        RUN: begin
          if (w_md_done) begin
            r_state     <= DONE;
            r_result    <= w_md_result;
            r_fz        <= (w_md_result == '0);
            r_fc        <= 1'b0;
            r_fdz       <= 1'b0;
            r_out_valid <= 1'b1;
            r_acc       <= w_md_result[W-1:0];
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
      // Clear has priority over the DONE-entry accumulator update.
      if (acc_clr) r_acc <= '0;
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign out_valid  = r_out_valid;
  assign result     = r_result;
  assign flag_zero  = r_fz;
  assign flag_carry = r_fc;
  assign flag_dz    = r_fdz;

endmodule

// File: tb/tb_seq_calc_core.sv
// Self-checking bench for seq_calc_core (W=8): directed cases plus randomized commands
// compared against an arithmetic reference model.
module tb_seq_calc_core;

  localparam int W  = 8;
  localparam int RW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          use_acc;
  logic          acc_clr;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] result;
  logic          flag_zero;
  logic          flag_carry;
  logic          flag_dz;
  logic          busy;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_acc;

  always #5 clk = ~clk;

  seq_calc_core #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .a          (a),
    .b          (b),
    .use_acc    (use_acc),
    .acc_clr    (acc_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .flag_dz    (flag_dz),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation definitions.
  function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [RW-1:0] r, output logic z, output logic c,
                                output logic dz, output int lat);
    int unsigned ux;
    int unsigned uy;
    int unsigned base;
    ux   = x;
    uy   = y;
    base = 1 << W;
    c    = 1'b0;
    dz   = 1'b0;
    lat  = 1;
    case (o)
      3'd0: begin r = RW'(ux + uy); c = (ux + uy) >= base; end
      3'd1: begin r = RW'((ux + base - uy) % base); c = (ux < uy); end
      3'd2: begin r = RW'(ux * uy); lat = W + 1; end
      3'd3: begin
        if (uy == 0) begin
          r  = RW'(ux * base + base - 1);
          dz = 1'b1;
        end else begin
          r   = RW'((ux % uy) * base + ux / uy);
          lat = W + 1;
        end
      end
      3'd5:    r = RW'(x | y);
      3'd6:    r = RW'(x ^ y);
      default: r = RW'(x & y);
    endcase
    z = (r == '0);
  endfunction

  task automatic run_cmd(input logic [2:0] op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                         input logic ua, input logic clr, input int hold);
    logic [RW-1:0] er;
    logic          ez, ec, edz;
    int            elat;
    int            lat;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    model(op_i, ua ? m_acc : a_i, b_i, er, ez, ec, edz, elat);
    op        = op_i;
    a         = a_i;
    b         = b_i;
    use_acc   = ua;
    acc_clr   = clr;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    acc_clr  = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    use_acc  = 1'($urandom);
    op       = 3'($urandom);
    chk("busy_after_accept", {busy, in_ready}, 2'b10);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, elat);
    chk("result", result, er);
    chk("flags_zcd", {flag_zero, flag_carry, flag_dz}, {ez, ec, edz});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_stable", {out_valid, in_ready, flag_zero, flag_carry, flag_dz, result},
          {1'b1, 1'b0, ez, ec, edz, er});
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("after_handshake", {out_valid, in_ready, busy}, 3'b010);
    chk("result_kept", result, er);
    m_acc = (clr && elat == 1) ? '0 : er[W-1:0];
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = '0;
    a         = '0;
    b         = '0;
    use_acc   = 1'b0;
    acc_clr   = 1'b0;
    out_ready = 1'b1;
    m_acc     = '0;
    #12;
    chk("reset_outputs", {in_ready, busy, out_valid, flag_zero, flag_carry, flag_dz, result},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {RW{1'b0}}});
    @(negedge clk);
    rst_n = 1'b1;

    run_cmd(3'd0, 8'd200, 8'd100, 1'b0, 1'b0, 0);
    run_cmd(3'd1, 8'd5,   8'd7,   1'b0, 1'b0, 0);
    run_cmd(3'd2, 8'd255, 8'd255, 1'b0, 1'b0, 0);
    run_cmd(3'd2, 8'd0,   8'd77,  1'b0, 1'b0, 0);
    run_cmd(3'd3, 8'd100, 8'd7,   1'b0, 1'b0, 0);
    run_cmd(3'd3, 8'd100, 8'd0,   1'b0, 1'b0, 0);
    run_cmd(3'd0, 8'd33,  8'd44,  1'b0, 1'b0, 5);
    run_cmd(3'd7, 8'hF0,  8'h3C,  1'b0, 1'b0, 0);
    run_cmd(3'd0, 8'd10,  8'd3,   1'b0, 1'b0, 0);
    run_cmd(3'd0, 8'd0,   8'd4,   1'b1, 1'b0, 0);
    chk("acc_sum", m_acc, 8'd17);
    run_cmd(3'd0, 8'd1,   8'd1,   1'b0, 1'b1, 0);
    run_cmd(3'd0, 8'd99,  8'd0,   1'b1, 1'b0, 0);
    run_cmd(3'd2, 8'd12,  8'd13,  1'b1, 1'b1, 2);

    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] rb;
      rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      run_cmd(3'($urandom_range(0, 7)), W'($urandom), rb, 1'($urandom),
              $urandom_range(0, 7) == 0, $urandom_range(0, 3));
    end

    // Reset in the middle of a multiply abandons it.
    @(negedge clk);
    op       = 3'd2;
    a        = 8'd255;
    b        = 8'd255;
    use_acc  = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_mul", {in_ready, busy, out_valid, flag_zero, flag_carry, flag_dz, result},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {RW{1'b0}}});
    m_acc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_output_after_reset", {out_valid, in_ready}, 2'b01);
    run_cmd(3'd0, 8'd1, 8'd1, 1'b0, 1'b0, 0);
    run_cmd(3'd0, 8'd0, 8'd0, 1'b1, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
